// File: rtl/jesd_tx_lane_seq.sv
// JESD204B per-lane TX link-layer sequencer: CGS -> ILAS -> DATA, one octet per clk.
// Optional: `define JESD_TX_CHAR_REPLACE_EN for frame-end character replacement in DATA.
module jesd_tx_lane_seq #(
  parameter int F       = 1,
  parameter int K       = 32,
  parameter int ILAS_MF = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_sync_n,
  input  logic [111:0] i_cfg,
  input  logic [7:0]   i_data,
  output logic         o_ready,
  output logic [7:0]   o_data,
  output logic         o_k,
  output logic         o_lmfc,
  output logic [1:0]   o_state
);
  localparam int FK = F * K;
  localparam int PW = $clog2(FK);
  localparam int OW = (F > 1) ? $clog2(F) : 1;
  localparam int FW = (K > 1) ? $clog2(K) : 1;
  localparam int MW = $clog2(ILAS_MF);

  localparam logic [1:0] ST_CGS  = 2'b00;
  localparam logic [1:0] ST_ILAS = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;

  localparam logic [OW-1:0] OCT_LAST = OW'(F - 1);
  localparam logic [FW-1:0] FR_LAST  = FW'(K - 1);
  localparam logic [MW-1:0] MF_LAST  = MW'(ILAS_MF - 1);

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic [1:0] st;
  } oct_t;

  logic [1:0]    sync_q;
  logic          sync_s;
  logic [OW-1:0] oct_cnt;
  logic [FW-1:0] fr_cnt;
  logic [PW-1:0] pos;
  logic          boundary;
  logic [1:0]    st, st_n;
  logic [MW-1:0] mf_cnt;
  logic [1:0]    lo_cnt;
  logic          loss;
  logic [7:0]    cfg_arr [16];
  logic [3:0]    cfg_idx;
  oct_t          nxt;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], i_sync_n};
  end
  assign sync_s = sync_q[1];

  // LMFC position counters free-run regardless of link state
  always_ff @(posedge clk) begin
    if (rst) begin
      oct_cnt <= '0;
      fr_cnt  <= '0;
    end else if (oct_cnt == OCT_LAST) begin
      oct_cnt <= '0;
      fr_cnt  <= (fr_cnt == FR_LAST) ? '0 : fr_cnt + FW'(1);
    end else begin
      oct_cnt <= oct_cnt + OW'(1);
    end
  end
  assign pos      = PW'(fr_cnt) * PW'(F) + PW'(oct_cnt);
  assign boundary = (oct_cnt == OCT_LAST) && (fr_cnt == FR_LAST);

  // Fourth consecutive low of sync_s while linked drops back to CGS
  assign loss    = (st != ST_CGS) && !sync_s && (lo_cnt == 2'd3);
  assign o_ready = (st == ST_DATA) && !loss && !rst;

  always_comb begin
    st_n = st;
    case (st)
      ST_CGS:  if (sync_s && boundary) st_n = ST_ILAS;
      ST_ILAS: if (loss) st_n = ST_CGS;
               else if (boundary && mf_cnt == MF_LAST) st_n = ST_DATA;
      ST_DATA: if (loss) st_n = ST_CGS;
      default: st_n = ST_CGS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ST_CGS;
      mf_cnt <= '0;
      lo_cnt <= 2'd0;
    end else begin
      st <= st_n;
      if (loss || st == ST_CGS) mf_cnt <= '0;
      else if (st == ST_ILAS && boundary)
        mf_cnt <= (mf_cnt == MF_LAST) ? '0 : mf_cnt + MW'(1);
      if (st == ST_CGS || sync_s) lo_cnt <= 2'd0;
      else if (lo_cnt != 2'd3)    lo_cnt <= lo_cnt + 2'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) cfg_arr[i] = 8'h00;
    for (int i = 0; i < 14; i++) cfg_arr[i] = i_cfg[8*i +: 8];
  end
  assign cfg_idx = pos[3:0] - 4'd2;

`ifdef JESD_TX_CHAR_REPLACE_EN
  logic [7:0] last_oct;
  logic       last_vld;

  // Holds the unreplaced last octet of the previous frame; cleared outside DATA
  always_ff @(posedge clk) begin
    if (rst || st != ST_DATA || loss) begin
      last_oct <= 8'h00;
      last_vld <= 1'b0;
    end else if (oct_cnt == OCT_LAST) begin
      last_oct <= i_data;
      last_vld <= 1'b1;
    end
  end
`endif

  always_comb begin
    nxt = '{d: 8'hBC, k: 1'b1, st: ST_CGS};
    if (!loss) begin
      case (st)
        ST_ILAS: begin
          nxt = '{d: 8'(pos), k: 1'b0, st: ST_ILAS};
          if (pos == '0)                          begin nxt.d = 8'h1C; nxt.k = 1'b1; end
          else if (boundary)                      begin nxt.d = 8'h7C; nxt.k = 1'b1; end
          else if (mf_cnt == MW'(1)) begin
            if (pos == PW'(1))                    begin nxt.d = 8'h9C; nxt.k = 1'b1; end
            else if (pos < PW'(16))               nxt.d = cfg_arr[cfg_idx];
          end
        end
        ST_DATA: begin
          nxt = '{d: i_data, k: 1'b0, st: ST_DATA};
`ifdef JESD_TX_CHAR_REPLACE_EN
          if (oct_cnt == OCT_LAST && last_vld && i_data == last_oct) begin
            nxt.d = boundary ? 8'h7C : 8'hFC;
            nxt.k = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data  <= 8'hBC;
      o_k     <= 1'b1;
      o_lmfc  <= 1'b0;
      o_state <= ST_CGS;
    end else begin
      o_data  <= nxt.d;
      o_k     <= nxt.k;
      o_lmfc  <= (pos == '0);
      o_state <= nxt.st;
    end
  end
endmodule

// File: tb/tb_jesd_tx_lane_seq.sv
// Bench for jesd_tx_lane_seq: two lanes (F=1/K=32/4 MF and F=2/K=16/2 MF) against a cycle-indexed model.
module tb_jesd_tx_lane_seq;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_sync_n = 1'b0;
  logic [111:0] i_cfg;
  logic [7:0]   i_data = 8'h00;
  logic         rdy0, rdy1, k0, k1, l0, l1;
  logic [7:0]   d0, d1;
  logic [1:0]   s0, s1;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int t;
  int mode [2];
  int t0   [2];
  int lows [2];
  logic [7:0] lo [2];
  bit  lv [2];
  bit  sh [2];
  int  fa [2];
  int  ka [2];
  int  ima[2];
  logic [7:0] e_d [2];
  logic       e_k [2];
  logic       e_l [2];
  logic       e_r [2];
  logic [1:0] e_s [2];
  logic [7:0] dcnt;

  jesd_tx_lane_seq #(.F(1), .K(32), .ILAS_MF(4)) u0 (
    .clk(clk), .rst(rst), .i_sync_n(i_sync_n), .i_cfg(i_cfg), .i_data(i_data),
    .o_ready(rdy0), .o_data(d0), .o_k(k0), .o_lmfc(l0), .o_state(s0));

  jesd_tx_lane_seq #(.F(2), .K(16), .ILAS_MF(2)) u1 (
    .clk(clk), .rst(rst), .i_sync_n(i_sync_n), .i_cfg(i_cfg), .i_data(i_data),
    .o_ready(rdy1), .o_data(d1), .o_k(k1), .o_lmfc(l1), .o_state(s1));

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_rdy0", rdy0, 0);
    chk("rst_rdy1", rdy1, 0);
    @(posedge clk); #1;
    chk("rst_d0", d0, 8'hBC); chk("rst_k0", k0, 1); chk("rst_l0", l0, 0); chk("rst_s0", s0, 0);
    chk("rst_d1", d1, 8'hBC); chk("rst_k1", k1, 1); chk("rst_l1", l1, 0); chk("rst_s1", s1, 0);
    t = 0;
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; t0[i] = 0; lows[i] = 0; lv[i] = 0; lo[i] = 8'h00;
    end
    sh[0] = 0; sh[1] = 0;
  endtask

  // One octet time: cycle t has position t mod F*K; sync_s lags i_sync_n by two cycles.
  task automatic step(input logic sn, input logic [7:0] d);
    bit s;
    @(negedge clk); rst = 1'b0; i_sync_n = sn; i_data = d; #1;
    s = sh[0]; sh[0] = sh[1]; sh[1] = sn;
    for (int i = 0; i < 2; i++) begin
      int fk, p, mf, ln;
      bit lost;
      fk = fa[i] * ka[i];
      p  = t % fk;
      mf = (t - t0[i]) / fk;
      ln = (mode[i] != 0 && !s) ? lows[i] + 1 : 0;
      lost = (ln >= 4);
      if (lost || mode[i] != 2) lv[i] = 0;
      e_r[i] = (mode[i] == 2) && !lost;
      e_l[i] = (p == 0);
      e_d[i] = 8'hBC; e_k[i] = 1; e_s[i] = 0;
      if (!lost && mode[i] == 1) begin
        e_s[i] = 1;
        if (p == 0) e_d[i] = 8'h1C;
        else if (p == fk - 1) e_d[i] = 8'h7C;
        else if (mf == 1 && p == 1) e_d[i] = 8'h9C;
        else begin
          e_k[i] = 0;
          if (mf == 1 && p <= 15) e_d[i] = i_cfg[8*(p-2) +: 8];
          else e_d[i] = p[7:0];
        end
      end else if (!lost && mode[i] == 2) begin
        e_s[i] = 2; e_k[i] = 0; e_d[i] = d;
`ifdef JESD_TX_CHAR_REPLACE_EN
        if (p % fa[i] == fa[i] - 1) begin
          if (lv[i] && d == lo[i]) begin
            e_k[i] = 1;
            e_d[i] = (p == fk - 1) ? 8'h7C : 8'hFC;
          end
          lo[i] = d; lv[i] = 1;
        end
`endif
      end
      chk($sformatf("u%0d_rdy", i), (i == 0) ? rdy0 : rdy1, e_r[i]);
      lows[i] = lost ? 0 : ln;
      if (lost) mode[i] = 0;
      else if (mode[i] == 0 && s && p == fk - 1) begin mode[i] = 1; t0[i] = t + 1; end
      else if (mode[i] == 1 && p == fk - 1 && mf == ima[i] - 1) mode[i] = 2;
    end
    @(posedge clk); #1;
    chk("u0_data", d0, e_d[0]); chk("u0_k", k0, e_k[0]);
    chk("u0_lmfc", l0, e_l[0]); chk("u0_state", s0, e_s[0]);
    chk("u1_data", d1, e_d[1]); chk("u1_k", k1, e_k[1]);
    chk("u1_lmfc", l1, e_l[1]); chk("u1_state", s1, e_s[1]);
    t++;
  endtask

  initial begin
    int lim;
    fa[0] = 1;  fa[1] = 2;
    ka[0] = 32; ka[1] = 16;
    ima[0] = 4; ima[1] = 2;
    i_cfg = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
    t = 0;
    do_reset();
    // CGS with SYNC~ held low
    repeat (200) step(1'b0, 8'($urandom()));
    // raise SYNC~ mid-multiframe, run through ILAS into DATA
    while (t % 32 != 10) step(1'b0, 8'($urandom()));
    repeat (200) step(1'b1, 8'($urandom()));
    // incrementing user data
    dcnt = 8'h00;
    repeat (80) begin step(1'b1, dcnt); dcnt++; end
    // glitch ignored, then real loss and relink
    repeat (3) step(1'b0, 8'($urandom()));
    repeat (20) step(1'b1, 8'($urandom()));
    repeat (5) step(1'b0, 8'($urandom()));
    repeat (250) step(1'b1, 8'($urandom()));
    // constant data exercises frame-end handling
    repeat (100) step(1'b1, 8'hA5);
    // drop link, relink, reset in the middle of ILAS multiframe 2
    repeat (6) step(1'b0, 8'($urandom()));
    lim = 0;
    while (!(mode[0] == 1 && (t - t0[0]) / 32 == 2 && t % 32 == 5) && lim < 400) begin
      step(1'b1, 8'($urandom()));
      lim++;
    end
    n_chk++;
    assert (lim < 400) n_pass++;
    else begin
      n_fail++;
      $error("FAIL ilas_reach observed=%0d expected<400", lim);
    end
    do_reset();
    repeat (40) step(1'b1, 8'($urandom()));
    // random SYNC~ low bursts over a small data alphabet
    repeat (30) begin
      repeat ($urandom_range(1, 6)) step(1'b0, 8'($urandom_range(0, 3)));
      repeat ($urandom_range(20, 120)) step(1'b1, 8'($urandom_range(0, 3)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/jesd_tx_lane_seq.md
Name: jesd_tx_lane_seq

Overview:
- Per-lane JESD204B TX link-layer sequencer, one octet per clock.
- Sits between the transport layer and the 8b10b encoder, whose running-disparity tracker follows each emitted character.
- Generates CGS (/K/ K28.5), then the ILAS multiframes (/R/, /Q/, /A/, 14 configuration octets, ramp filler), then passes user data.
- Tracks LMFC locally and reacts to SYNC~ requests and losses.

Parameters:
- F, 1, octets per frame (1..256).
- K, 32, frames per multiframe; F*K must be 17..1024.
- ILAS_MF, 4, number of ILAS multiframes (2..8).

Ports:
- clk  in  1  sole clock, octet rate.
- rst  in  1  reset.
- i_sync_n  in  1  SYNC~ from receiver, asynchronous, active low.
- i_cfg  in  112  ILAS link configuration octets; octet i = i_cfg[8i+7:8i]; static outside CGS.
- i_data  in  8  user octet from transport layer.
- o_ready  out  1  i_data consumed this cycle.
- o_data  out  8  octet to encoder.
- o_k  out  1  1 = o_data is a K character.
- o_lmfc  out  1  o_data is multiframe position 0.
- o_state  out  2  00 CGS, 01 ILAS, 10 DATA.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- **SYNC~ synchronizer**
  - i_sync_n passes a 2-flop synchronizer; sync_s is the synchronized value.
  - Both flops reset to 0 (SYNC~ asserted).
- **Counters**
  - oct_cnt counts 0..F-1; fr_cnt counts 0..K-1.
  - Multiframe position p = fr_cnt*F + oct_cnt.
  - Counters free-run in every state and reset to 0.
  - Boundary = p wraps from F*K-1 to 0.
- **Output timing**
  - o_data, o_k, o_lmfc and o_state are registered.
  - The octet for position p appears one cycle after the counters hold p.
- **Reset values**
  - State CGS, o_data=8'hBC, o_k=1, o_lmfc=0, o_ready=0, o_state=00.
  - mf_cnt=0, all counters 0.
  - Reset has the same effect in any state, including mid-ILAS or mid-DATA.
- **CGS state**
  - Emit 8'hBC with k=1 every octet.
  - If sync_s=1 during the cycle the counters hold p=F*K-1, go to ILAS; the first ILAS octet is p=0 of the next multiframe.
  - If sync_s rises mid-multiframe, hold CGS until that boundary.
- **ILAS state** (mf_cnt 0..ILAS_MF-1, increments at each boundary)
  - p=0: 8'h1C, k=1.
  - p=F*K-1: 8'h7C, k=1.
  - mf_cnt=1, p=1: 8'h9C, k=1.
  - mf_cnt=1, p=2..15: i_cfg octet p-2, k=0.
  - All other positions: p[7:0], k=0 (ramp).
  - After the /A/ of mf_cnt=ILAS_MF-1, go to DATA at the boundary.
- **DATA state**
  - o_ready=1 in every cycle whose counter position maps to a DATA output octet.
  - i_data sampled in that cycle appears on o_data next cycle with k=0.
  - Upstream supplies a valid octet every ready cycle; there is no stall.
- **SYNC~ loss**
  - In ILAS or DATA, sync_s=0 for 4 consecutive cycles forces CGS.
  - o_ready drops in the same cycle the decision registers.
  - The next emitted octet is 8'hBC; mf_cnt clears; counters keep running.
  - A low pulse of 1–3 cycles is ignored.
- **o_lmfc**
  - 1 for exactly one cycle per multiframe in all states, coincident with the p=0 octet.
- **o_state**
  - Reflects the state of the octet currently on o_data.

Optional Feature:
- Macro: JESD_TX_CHAR_REPLACE_EN.
- **Defined:** DATA-state frame-end character replacement (non-scrambled link).
  - Applies to the octet at oct_cnt=F-1 when it equals the unreplaced last octet of the previous frame.
  - At p=F*K-1 it is replaced by 8'h7C, k=1; otherwise by 8'hFC, k=1.
  - The comparison register always stores the original octet.
  - It is invalidated on entry to DATA, so there is no replacement in the first DATA frame.
- **Undefined:** all DATA octets pass unchanged with k=0; no comparison logic is present.

Test Plan:
1. rst=1 one cycle, i_sync_n=0 for 200 cycles -> o_data=8'hBC, o_k=1 every cycle, o_ready=0, o_state=00, o_lmfc pulse every 32 cycles.
2. F=1, K=32, ILAS_MF=4; raise i_sync_n at p=10 -> CGS until boundary, then 128 ILAS octets:
   - 8'h1C with o_lmfc at each p=0; 8'h7C at each p=31.
   - MF1: 8'h9C at p=1 and i_cfg octets 0..13 at p=2..15.
   - Ramp 8'h10..8'h1E at MF1 p=16..30; ramp 8'h01..8'h1E elsewhere.
   - Then o_state=10.
3. DATA: drive i_data=8'h00,8'h01,... on ready cycles -> o_data repeats them one cycle later, o_k=0, no gaps.
4. DATA: i_sync_n low 3 cycles -> no change; low 4 cycles -> o_ready falls, o_data=8'hBC, o_state=00; ILAS restarts only at a boundary after SYNC~ returns high.
5. F=2, macro defined, constant i_data=8'hA5 -> first DATA frame 8'hA5,8'hA5; later frame ends 8'hFC k=1, multiframe end 8'h7C k=1. Macro undefined -> all 8'hA5, k=0.
6. rst=1 mid-ILAS (mf_cnt=2) -> next cycle o_data=8'hBC, o_state=00, counters 0, o_lmfc=0.
